// File: rtl/instr_encoder.sv
// MIPS instruction encoder for program load: turns field-level requests into
// 32-bit words and streams them to sequential instruction-memory addresses.
module instr_encoder #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_imm,
  input  logic [ADDR_W-1:0] in_target,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);

  logic [1:0]        r_state;
  logic [ADDR_W:0]   r_count;
  logic              r_err;
  logic              r_wr_valid;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [31:0]       r_wr_data;

  logic                     w_full;
  logic                     w_accept;
  logic [ADDR_W-1:0]        w_addr;
  logic signed [ADDR_W:0]   w_off;
  logic [15:0]              w_off16;
  logic [31:0]              w_word;

  // count can only reach 2^ADDR_W, so its top bit alone means "memory full"
  assign w_full   = r_count[ADDR_W];
  assign in_ready = (r_state == S_LOAD) && !w_full && (!r_wr_valid || wr_ready);
  assign w_accept = in_valid && in_ready;
  assign w_addr   = BASE + r_count[ADDR_W-1:0];

  // Branch offset relative to the following word, ADDR_W+1-bit two's complement
  assign w_off   = signed'({1'b0, in_target} - {1'b0, w_addr} - CNT_ONE);
  assign w_off16 = 16'(w_off);

  always_comb begin
    w_word = '0;
    case (in_kind)
      3'd0:    w_word = {6'b000000, in_rs, in_rt, in_rd, in_shamt, in_funct};
      3'd1:    w_word = {6'b001000, in_rs, in_rt, in_imm};
      3'd2:    w_word = {6'b001100, in_rs, in_rt, in_imm};
      3'd3:    w_word = {6'b100011, in_rs, in_rt, in_imm};
      3'd4:    w_word = {6'b101011, in_rs, in_rt, in_imm};
      3'd5:    w_word = {6'b000100, in_rs, in_rt, w_off16};
      3'd6:    w_word = {6'b000101, in_rs, in_rt, w_off16};
      default: w_word = {6'b000010, 26'(in_target)};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_err      <= 1'b0;
      r_wr_valid <= 1'b0;
      r_wr_addr  <= BASE;
      r_wr_data  <= '0;
    end else begin
      if (w_accept) begin
        r_wr_valid <= 1'b1;
        r_wr_addr  <= w_addr;
        r_wr_data  <= w_word;
        r_count    <= r_count + CNT_ONE;
      end else if (wr_ready) begin
        r_wr_valid <= 1'b0;
      end

      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state <= S_LOAD;
            r_count <= '0;
            r_err   <= 1'b0;
          end
        end
        S_LOAD: begin
          if (in_valid && w_full) r_err <= 1'b1;
          if (finish) r_state <= S_DRAIN;
        end
        default: begin
          if (!r_wr_valid) r_state <= S_DONE;
        end
      endcase
    end
  end

  assign wr_valid = r_wr_valid;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign busy     = (r_state == S_LOAD) || (r_state == S_DRAIN);
  assign done     = (r_state == S_DONE);
  assign err      = r_err;
  assign count    = r_count;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed encodings, stall, full/err, reset in DRAIN,
// and a randomized run scored against an arithmetic encoding model.
module tb_instr_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int checks = 0;
  int failures = 0;

  logic [2:0]  kind;
  logic [4:0]  rs, rt, rd, sh;
  logic [5:0]  fn;
  logic [15:0] imm;

  logic a_start, a_finish, a_in_valid, a_in_ready, a_wr_valid, a_wr_ready;
  logic a_busy, a_done, a_err;
  logic [7:0]  a_target, a_wr_addr;
  logic [31:0] a_wr_data;
  logic [8:0]  a_count;

  logic b_start, b_finish, b_in_valid, b_in_ready, b_wr_valid, b_wr_ready;
  logic b_busy, b_done, b_err;
  logic [1:0]  b_target, b_wr_addr;
  logic [31:0] b_wr_data;
  logic [2:0]  b_count;

  instr_encoder #(.ADDR_W(8), .BASE_ADDR(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .finish(a_finish),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_kind(kind),
    .in_rs(rs), .in_rt(rt), .in_rd(rd), .in_shamt(sh), .in_funct(fn),
    .in_imm(imm), .in_target(a_target), .wr_valid(a_wr_valid),
    .wr_ready(a_wr_ready), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .busy(a_busy), .done(a_done), .err(a_err), .count(a_count)
  );

  instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .finish(b_finish),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_kind(kind),
    .in_rs(rs), .in_rt(rt), .in_rd(rd), .in_shamt(sh), .in_funct(fn),
    .in_imm(imm), .in_target(b_target), .wr_valid(b_wr_valid),
    .wr_ready(b_wr_ready), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .busy(b_busy), .done(b_done), .err(b_err), .count(b_count)
  );

  int OPS[8] = '{0, 8, 12, 35, 43, 4, 5, 2};

  // Reference encoding from the instruction formats, using the shared field inputs
  function automatic logic [31:0] enc(input int k, input int tgt, input int addr);
    int w;
    int off;
    w = 0;
    off = tgt - (addr + 1);
    case (k)
      0:          w = (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | (32'(sh) << 6) | 32'(fn);
      1, 2, 3, 4: w = (OPS[k] << 26) | (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm);
      5, 6:       w = (OPS[k] << 26) | (32'(rs) << 21) | (32'(rt) << 16) | (off & 32'hFFFF);
      default:    w = (OPS[7] << 26) | tgt;
    endcase
    return 32'(w);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input int k, input int r1, input int r2, input int r3,
                            input int s, input int f, input int i);
    kind = 3'(k); rs = 5'(r1); rt = 5'(r2); rd = 5'(r3);
    sh = 5'(s); fn = 6'(f); imm = 16'(i);
  endtask

  task automatic a_pulse_start();
    a_start = 1'b1; tick(); a_start = 1'b0;
  endtask

  task automatic a_pulse_finish();
    a_finish = 1'b1; tick(); a_finish = 1'b0;
  endtask

  task automatic a_send(input logic [7:0] tgt);
    int n;
    n = 0;
    a_target = tgt;
    a_in_valid = 1'b1;
    #1;
    while (!a_in_ready && n < 20) begin tick(); #1; n++; end
    checks++;
    if (a_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL a_send_accept in_ready=%b required=1", a_in_ready);
    end
    tick();
    a_in_valid = 1'b0;
  endtask

  task automatic a_wait_done();
    int n;
    n = 0;
    while (!a_done && n < 20) begin tick(); n++; end
    checks++;
    if (a_done !== 1'b1) begin
      failures++;
      $display("FAIL a_done_timeout done=%b required=1", a_done);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({a_in_ready, a_wr_valid, a_busy, a_done, a_err} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags_a got=%b required=00000", {a_in_ready, a_wr_valid, a_busy, a_done, a_err});
    end
    checks++;
    if (a_wr_addr !== 8'd0 || a_wr_data !== 32'd0 || a_count !== 9'd0) begin
      failures++;
      $display("FAIL reset_regs_a addr=%h data=%h count=%0d required=0/0/0", a_wr_addr, a_wr_data, a_count);
    end
    checks++;
    if ({b_in_ready, b_wr_valid, b_busy, b_done, b_err} !== 5'b0 || b_count !== 3'd0) begin
      failures++;
      $display("FAIL reset_b flags=%b count=%0d required=0", {b_in_ready, b_wr_valid, b_busy, b_done, b_err}, b_count);
    end
  endtask

  task automatic check_a_word(input string name, input logic [7:0] addr,
                              input logic [31:0] data, input logic [8:0] cnt);
    checks++;
    if (a_wr_valid !== 1'b1 || a_wr_addr !== addr || a_wr_data !== data || a_count !== cnt) begin
      failures++;
      $display("FAIL %s valid=%b addr=%0d data=%h count=%0d required 1/%0d/%h/%0d",
               name, a_wr_valid, a_wr_addr, a_wr_data, a_count, addr, data, cnt);
    end
  endtask

  task automatic test_encode();
    a_wr_ready = 1'b1;
    a_pulse_start();
    set_fields(1, 1, 2, 0, 0, 0, 16'h0005);  a_send(8'd0);
    check_a_word("enc_addi", 8'd0, 32'h20220005, 9'd1);
    set_fields(0, 1, 2, 3, 0, 6'h20, 0);     a_send(8'd0);
    check_a_word("enc_r", 8'd1, 32'h00221820, 9'd2);
    set_fields(7, 0, 0, 0, 0, 0, 0);         a_send(8'h10);
    check_a_word("enc_j", 8'd2, 32'h08000010, 9'd3);
    a_pulse_finish();
    a_wait_done();
    a_pulse_start();
    checks++;
    if (a_count !== 9'd0 || a_busy !== 1'b1 || a_done !== 1'b0) begin
      failures++;
      $display("FAIL restart count=%0d busy=%b done=%b required 0/1/0", a_count, a_busy, a_done);
    end
    for (int i = 0; i < 4; i++) begin
      set_fields(1, i, i, 0, 0, 0, i);
      a_send(8'd0);
    end
    set_fields(5, 1, 0, 0, 0, 0, 0);         a_send(8'd2);
    check_a_word("enc_beq", 8'd4, 32'h1020FFFD, 9'd5);
    set_fields(6, 1, 0, 0, 0, 0, 0);         a_send(8'd2);
    check_a_word("enc_bne", 8'd5, 32'h1420FFFC, 9'd6);
    a_pulse_finish();
    a_wait_done();
  endtask

  task automatic test_back_to_back();
    logic [31:0] w1, w2;
    a_pulse_start();
    a_wr_ready = 1'b0;
    set_fields(1, 3, 4, 0, 0, 0, 16'h1111);
    w1 = enc(1, 0, 0);
    a_target = 8'd0;
    a_in_valid = 1'b1;
    tick();
    set_fields(2, 5, 6, 0, 0, 0, 16'hABCD);
    w2 = enc(2, 0, 1);
    #1;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (a_in_ready !== 1'b0 || a_wr_valid !== 1'b1 || a_wr_addr !== 8'd0 || a_wr_data !== w1) begin
        failures++;
        $display("FAIL stall_hold cyc=%0d ready=%b valid=%b addr=%0d data=%h required 0/1/0/%h",
                 c, a_in_ready, a_wr_valid, a_wr_addr, a_wr_data, w1);
      end
      tick(); #1;
    end
    a_wr_ready = 1'b1;
    #1;
    checks++;
    if (a_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL stall_release in_ready=%b required=1", a_in_ready);
    end
    tick();
    a_in_valid = 1'b0;
    #1;
    check_a_word("stall_second", 8'd1, w2, 9'd2);
    tick();
    checks++;
    if (a_wr_valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_drain wr_valid=%b required=0", a_wr_valid);
    end
    a_pulse_finish();
    a_wait_done();
  endtask

  task automatic test_random();
    logic [39:0] q[$];
    int cnt;
    cnt = 0;
    a_wr_ready = 1'b1;
    a_pulse_start();
    for (int c = 0; c < 300; c++) begin
      a_in_valid = 1'($urandom_range(0, 1));
      kind = 3'($urandom); rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
      sh = 5'($urandom); fn = 6'($urandom); imm = 16'($urandom);
      a_target = 8'($urandom);
      a_wr_ready = ($urandom_range(0, 3) != 0);
      a_start = ($urandom_range(0, 15) == 0);
      #1;
      checks++;
      if (a_wr_valid !== (q.size() != 0) || a_count !== 9'(cnt) ||
          a_in_ready !== ((q.size() == 0 || a_wr_ready) && cnt < 256)) begin
        failures++;
        $display("FAIL rand_ctrl cyc=%0d valid=%b ready=%b count=%0d required %b/%b/%0d",
                 c, a_wr_valid, a_in_ready, a_count, q.size() != 0,
                 (q.size() == 0 || a_wr_ready) && cnt < 256, cnt);
      end
      if (a_wr_valid && a_wr_ready && q.size() != 0) begin
        checks++;
        if (a_wr_addr !== q[0][39:32] || a_wr_data !== q[0][31:0]) begin
          failures++;
          $display("FAIL rand_word cyc=%0d addr=%0d data=%h required %0d/%h",
                   c, a_wr_addr, a_wr_data, q[0][39:32], q[0][31:0]);
        end
        void'(q.pop_front());
      end
      if (a_in_valid && a_in_ready) begin
        q.push_back({8'(cnt), enc(int'(kind), int'(a_target), cnt % 256)});
        cnt++;
      end
      tick();
    end
    a_in_valid = 1'b0;
    a_start = 1'b0;
    a_wr_ready = 1'b1;
    #1;
    if (q.size() != 0) begin
      checks++;
      if (a_wr_valid !== 1'b1 || a_wr_addr !== q[0][39:32] || a_wr_data !== q[0][31:0]) begin
        failures++;
        $display("FAIL rand_last valid=%b addr=%0d data=%h required 1/%0d/%h",
                 a_wr_valid, a_wr_addr, a_wr_data, q[0][39:32], q[0][31:0]);
      end
      void'(q.pop_front());
    end
    a_pulse_finish();
    a_wait_done();
    checks++;
    if (a_err !== 1'b0 || a_count !== 9'(cnt)) begin
      failures++;
      $display("FAIL rand_end err=%b count=%0d required 0/%0d", a_err, a_count, cnt);
    end
  endtask

  task automatic test_full();
    logic [31:0] exp;
    int n;
    b_wr_ready = 1'b1;
    b_start = 1'b1; tick(); b_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_fields(1, 1, 2, 0, 0, 0, i + 7);
      exp = enc(1, 0, i);
      b_target = 2'd0;
      b_in_valid = 1'b1;
      #1;
      checks++;
      if (b_in_ready !== 1'b1) begin
        failures++;
        $display("FAIL full_ready_%0d in_ready=%b required=1", i, b_in_ready);
      end
      tick();
      b_in_valid = 1'b0;
      checks++;
      if (b_wr_valid !== 1'b1 || b_wr_addr !== 2'(i) || b_wr_data !== exp || b_count !== 3'(i + 1)) begin
        failures++;
        $display("FAIL full_word_%0d valid=%b addr=%0d data=%h count=%0d required 1/%0d/%h/%0d",
                 i, b_wr_valid, b_wr_addr, b_wr_data, b_count, i, exp, i + 1);
      end
    end
    b_in_valid = 1'b1;
    #1;
    checks++;
    if (b_in_ready !== 1'b0 || b_err !== 1'b0) begin
      failures++;
      $display("FAIL full_block in_ready=%b err=%b required 0/0", b_in_ready, b_err);
    end
    tick();
    b_in_valid = 1'b0;
    checks++;
    if (b_err !== 1'b1 || b_count !== 3'd4 || b_wr_valid !== 1'b0) begin
      failures++;
      $display("FAIL full_err err=%b count=%0d valid=%b required 1/4/0", b_err, b_count, b_wr_valid);
    end
    b_finish = 1'b1; tick(); b_finish = 1'b0;
    checks++;
    if (b_busy !== 1'b1 || b_done !== 1'b0) begin
      failures++;
      $display("FAIL full_drain busy=%b done=%b required 1/0", b_busy, b_done);
    end
    n = 0;
    while (!b_done && n < 20) begin tick(); n++; end
    checks++;
    if (b_done !== 1'b1 || b_busy !== 1'b0 || b_err !== 1'b1 || b_count !== 3'd4) begin
      failures++;
      $display("FAIL full_done done=%b busy=%b err=%b count=%0d required 1/0/1/4", b_done, b_busy, b_err, b_count);
    end
    b_start = 1'b1; tick(); b_start = 1'b0;
    checks++;
    if (b_err !== 1'b0 || b_count !== 3'd0 || b_busy !== 1'b1) begin
      failures++;
      $display("FAIL full_restart err=%b count=%0d busy=%b required 0/0/1", b_err, b_count, b_busy);
    end
  endtask

  task automatic test_reset_drain();
    a_pulse_start();
    a_wr_ready = 1'b0;
    set_fields(1, 9, 10, 0, 0, 0, 16'h0042);
    a_send(8'd0);
    a_pulse_finish();
    #1;
    checks++;
    if (a_busy !== 1'b1 || a_wr_valid !== 1'b1) begin
      failures++;
      $display("FAIL rst_pre busy=%b valid=%b required 1/1", a_busy, a_wr_valid);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({a_in_ready, a_wr_valid, a_busy, a_done, a_err} !== 5'b0 ||
        a_wr_addr !== 8'd0 || a_wr_data !== 32'd0 || a_count !== 9'd0) begin
      failures++;
      $display("FAIL rst_drain flags=%b addr=%0d data=%h count=%0d required 0",
               {a_in_ready, a_wr_valid, a_busy, a_done, a_err}, a_wr_addr, a_wr_data, a_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    a_wr_ready = 1'b1;
    a_pulse_start();
    set_fields(0, 7, 8, 9, 4, 6'h2A, 0);
    a_send(8'd0);
    check_a_word("rst_restart", 8'd0, enc(0, 0, 0), 9'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    a_start = 0; a_finish = 0; a_in_valid = 0; a_wr_ready = 0; a_target = '0;
    b_start = 0; b_finish = 0; b_in_valid = 0; b_wr_ready = 0; b_target = '0;
    set_fields(0, 0, 0, 0, 0, 0, 0);
    #12;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    test_encode();
    test_back_to_back();
    test_random();
    test_full();
    test_reset_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Program-load block that assembles MIPS instruction words from field-level requests and writes them sequentially into instruction memory. It is the encoding counterpart of the control decoder: every opcode the decoder recognises (R-type, addi, andi, lw, sw, beq, bne, j) is produced here with the identical opcode value. It sits between a host/loader front end and the instruction-memory write port, with valid/ready handshakes on both sides.

## Interface
- ADDR_W, 8, instruction-memory word-address width (legal 2..15)
- BASE_ADDR, 0, word address of the first instruction written after start

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a load session (honoured only in IDLE or DONE)
- finish  in  1  end of program (honoured only in LOAD)
- in_valid / in_ready  in / out  1  request handshake; transfer when both high
- in_kind  in  3  0 R, 1 addi, 2 andi, 3 lw, 4 sw, 5 beq, 6 bne, 7 j
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register/shift fields
- in_funct  in  6  R-type funct
- in_imm  in  16  immediate for addi/andi/lw/sw
- in_target  in  ADDR_W  absolute word address for beq/bne/j
- wr_valid / wr_ready  out / in  1  memory write handshake
- wr_addr  out  ADDR_W  word address of wr_data
- wr_data  out  32  encoded instruction
- busy  out  1  state is LOAD or DRAIN
- done  out  1  high while in DONE
- err  out  1  sticky overflow flag, cleared by start
- count  out  ADDR_W+1  words accepted this session

## Operation
- States: IDLE, LOAD, DRAIN, DONE. IDLE/DONE + start -> LOAD (count=0, err=0, next address=BASE_ADDR). LOAD + finish -> DRAIN. DRAIN -> DONE in the first cycle the output register is empty (DRAIN lasts at least one cycle). start outside IDLE/DONE ignored.
- One output register holds the pending word. in_ready = (state==LOAD) && count<2^ADDR_W && (output empty || wr_ready).
- Encoding, opcode in [31:26]: R {000000,rs,rt,rd,shamt,funct}; addi 001000, andi 001100, lw 100011, sw 101011 as {op,rs,rt,imm}; beq 000100, bne 000101 as {op,rs,rt,off16}; j {000010, zero-extended target to 26 bits}.
- Branch offset: off = in_target − (word address + 1), computed in ADDR_W+1 bits signed, sign-extended to 16. Word address = BASE_ADDR + count modulo 2^ADDR_W (wraps).
- Unused fields of a format are ignored.
- Full: when count==2^ADDR_W, in_ready=0; any in_valid in LOAD while full sets err. finish still completes normally.
- in_valid and finish in the same cycle: the request is accepted if in_ready, then state moves to DRAIN.
- rst_n low at any time: immediate return to IDLE, pending word discarded.

## Timing
- Reset values: in_ready 0, wr_valid 0, wr_addr BASE_ADDR, wr_data 0, busy 0, done 0, err 0, count 0.
- Latency: request accepted at edge N -> wr_valid=1 with data/address after edge N, held stable until wr_ready sampled high.
- Throughput one word per cycle when wr_ready stays high.
- count increments on the accepting edge; done rises the cycle after DRAIN sees an empty output register.

## Test plan
- addi rs=1 rt=2 imm=0x0005 first word -> wr_addr 0, wr_data 0x20220005, count 1.
- R rs=1 rt=2 rd=3 shamt=0 funct=0x20 -> wr_data 0x00221820; j target=0x10 -> 0x08000010.
- Four filler words then beq rs=1 rt=0 target=2 (address 4) -> wr_data 0x1020FFFD; bne same fields -> 0x1420FFFC at address 5.
- Two back-to-back requests with wr_ready low 3 cycles -> first word held stable, in_ready low, no loss, order and addresses 0,1 preserved.
- ADDR_W=2, five requests -> addresses 0..3 written, in_ready 0 after the fourth, err=1, count=4; finish -> DRAIN -> done=1.
- rst_n low during DRAIN with pending word -> all outputs return to reset values at once; new start writes from BASE_ADDR with count 0.
